// File: rtl/noise_pkg.sv
// Shared types and constant helpers for the sliding-window fetch controller.
// Holds the FSM state encoding and the window-side arithmetic used by the top and the tap counter.
package noise_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        OUT  = 3'd3,
        DONE = 3'd4
    } fetch_state_t;

    // Window side length K for a radius n.
    function automatic int win_side(input int n);
        return 2 * n + 1;
    endfunction

    // Index width able to hold 0..k-1, never narrower than one bit.
    function automatic int idx_width(input int k);
        return (k <= 2) ? 1 : $clog2(k);
    endfunction

endpackage

// File: rtl/window_fetch_ctrl_if.sv
// Pixel-memory read port and window-tap stream between the fetch controller and its neighbours.
// The master side is the controller; the slave side is the memory plus the downstream detector.
interface window_fetch_ctrl_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  rd_req;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_gnt;
    logic                  rd_valid;
    logic [7:0]            rd_data;

    logic                  win_valid;
    logic [7:0]            win_data;
    logic                  win_first;
    logic                  win_last;
    logic                  win_ready;

    modport master (
        output rd_req, rd_addr, win_valid, win_data, win_first, win_last,
        input  rd_gnt, rd_valid, rd_data, win_ready
    );

    modport slave (
        input  rd_req, rd_addr, win_valid, win_data, win_first, win_last,
        output rd_gnt, rd_valid, rd_data, win_ready
    );
endinterface

// File: rtl/window_tap_counter.sv
// Nested dy/dx tap index counter for one KxK window; dx is the inner (fast) index.
// Indices run 0..K-1 and are offset by the window radius in the address datapath.
module window_tap_counter
    import noise_pkg::*;
#(
    parameter int K  = 5,
    parameter int IW = idx_width(K)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    output logic [IW-1:0] dy_idx,
    output logic [IW-1:0] dx_idx,
    output logic          first,
    output logic          last,
    output logic          wrap
);

    localparam logic [IW-1:0] LAST_IDX = IW'(K - 1);

    logic [IW-1:0] r_dy;
    logic [IW-1:0] r_dx;
    logic          w_dx_end;
    logic          w_dy_end;

    assign w_dx_end = (r_dx == LAST_IDX);
    assign w_dy_end = (r_dy == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dy <= '0;
            r_dx <= '0;
        end else if (clr) begin
            r_dy <= '0;
            r_dx <= '0;
        end else if (inc) begin
            if (w_dx_end) begin
                r_dx <= '0;
                r_dy <= w_dy_end ? '0 : r_dy + 1'b1;
            end else begin
                r_dx <= r_dx + 1'b1;
            end
        end
    end

    assign dy_idx = r_dy;
    assign dx_idx = r_dx;
    assign first  = (r_dy == '0) && (r_dx == '0);
    assign last   = w_dy_end && w_dx_end;
    assign wrap   = inc && w_dy_end && w_dx_end;

endmodule

// File: rtl/window_fetch_ctrl.sv
// Walks every valid window center of an MxN image row-major and fetches its KxK taps one
// read at a time, handing each returned pixel to the detector over a valid/ready stream.
module window_fetch_ctrl
    import noise_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int WINDOW_N   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [15:0]           M,
    input  logic [15:0]           N,
    window_fetch_ctrl_if.master   bus,
    output logic [ADDR_WIDTH-1:0] center_addr,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  frame_err
);

    localparam int          K   = win_side(WINDOW_N);
    localparam int          IW  = idx_width(K);
    localparam logic [31:0] W32 = 32'(WINDOW_N);
    localparam logic [31:0] K32 = 32'(K);
    localparam logic [15:0] W16 = 16'(WINDOW_N);

    fetch_state_t  r_state;
    fetch_state_t  w_state_next;

    logic [15:0]   r_m;
    logic [15:0]   r_n;
    logic [15:0]   r_i;
    logic [15:0]   r_j;
    logic [7:0]    r_win_data;
    logic          r_frame_err;

    logic          w_accept;
    logic          w_dims_bad;
    logic          w_tap_adv;
    logic          w_tap_first;
    logic          w_tap_last;
    logic          w_tap_wrap;
    logic          w_i_last;
    logic          w_j_last;
    logic          w_frame_last;
    logic [IW-1:0] w_dy_idx;
    logic [IW-1:0] w_dx_idx;
    logic [31:0]   w_row;
    logic [31:0]   w_col;
    logic [31:0]   w_rd_addr32;
    logic [31:0]   w_center32;

    window_tap_counter #(
        .K  (K),
        .IW (IW)
    ) u_tap_counter (
        .clk    (clk),
        .rst_n  (rst),
        .clr    (w_accept),
        .inc    (w_tap_adv),
        .dy_idx (w_dy_idx),
        .dx_idx (w_dx_idx),
        .first  (w_tap_first),
        .last   (w_tap_last),
        .wrap   (w_tap_wrap)
    );

    // A frame with no complete window is finished immediately without touching memory.
    assign w_dims_bad   = ({16'd0, M} < K32) || ({16'd0, N} < K32);
    assign w_j_last     = ({16'd0, r_j} == ({16'd0, r_n} - W32 - 32'd1));
    assign w_i_last     = ({16'd0, r_i} == ({16'd0, r_m} - W32 - 32'd1));
    assign w_tap_adv    = (r_state == OUT) && bus.win_ready;
    assign w_frame_last = w_tap_last && w_j_last && w_i_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = w_dims_bad ? DONE : REQ;
                end
            end
            REQ:  if (bus.rd_gnt)    w_state_next = WAIT;
            WAIT: if (bus.rd_valid)  w_state_next = OUT;
            OUT:  if (bus.win_ready) w_state_next = w_frame_last ? DONE : REQ;
            DONE: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Dimensions are captured only on an accepted start so mid-frame input changes are inert.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_m         <= '0;
            r_n         <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_win_data  <= '0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_m         <= M;
                r_n         <= N;
                r_i         <= W16;
                r_j         <= W16;
                r_frame_err <= w_dims_bad;
            end
            if ((r_state == WAIT) && bus.rd_valid) begin
                r_win_data <= bus.rd_data;
            end
            if (w_tap_wrap) begin
                if (w_j_last) begin
                    r_j <= W16;
                    if (!w_i_last) begin
                        r_i <= r_i + 16'd1;
                    end
                end else begin
                    r_j <= r_j + 16'd1;
                end
            end
        end
    end

    // Tap indices are 0-based, so the radius is subtracted to get signed offsets around the center.
    assign w_row       = {16'd0, r_i} + 32'(w_dy_idx) - W32;
    assign w_col       = {16'd0, r_j} + 32'(w_dx_idx) - W32;
    assign w_rd_addr32 = w_row * {16'd0, r_n} + w_col;
    assign w_center32  = {16'd0, r_i} * {16'd0, r_n} + {16'd0, r_j};

    assign bus.rd_req    = (r_state == REQ);
    assign bus.rd_addr   = (r_state == REQ) ? ADDR_WIDTH'(w_rd_addr32) : '0;
    assign bus.win_valid = (r_state == OUT);
    assign bus.win_data  = r_win_data;
    assign bus.win_first = (r_state == OUT) && w_tap_first;
    assign bus.win_last  = (r_state == OUT) && w_tap_last;

    assign center_addr = ADDR_WIDTH'(w_center32);
    assign busy        = (r_state == REQ) || (r_state == WAIT) || (r_state == OUT);
    assign frame_done  = (r_state == DONE);
    assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_window_fetch_ctrl.sv
// Directed bench for window_fetch_ctrl (W=2, K=5) with a one-cycle pixel memory model.
// Expected addresses, centers and pixel values are rebuilt here from image geometry.
module tb_window_fetch_ctrl;

    localparam int AW = 8;

    logic          clk   = 1'b0;
    logic          rst   = 1'b0;
    logic          start = 1'b0;
    logic [15:0]   M     = '0;
    logic [15:0]   N     = '0;
    logic [AW-1:0] center_addr;
    logic          busy;
    logic          frame_done;
    logic          frame_err;

    window_fetch_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    window_fetch_ctrl #(
        .ADDR_WIDTH (AW),
        .WINDOW_N   (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .M           (M),
        .N           (N),
        .bus         (bus),
        .center_addr (center_addr),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pix(input logic [AW-1:0] a);
        return a ^ 8'h3C;
    endfunction

    // One-cycle memory; inj_valid lets the bench fake a stray late return.
    logic       mem_valid = 1'b0;
    logic [7:0] mem_data  = '0;
    logic       inj_valid = 1'b0;
    always @(posedge clk) begin
        mem_valid <= bus.rd_req && bus.rd_gnt;
        mem_data  <= pix(bus.rd_addr);
    end
    assign bus.rd_valid = mem_valid | inj_valid;
    assign bus.rd_data  = mem_data;

    typedef struct packed {
        logic [7:0]    d;
        logic          f;
        logic          l;
        logic [AW-1:0] c;
    } tap_t;

    logic [AW-1:0] rd_q[$];
    tap_t          tap_q[$];
    tap_t          mon_t;
    int            done_cnt = 0;
    int            lat_viol = 0;
    logic          p_rdv    = 1'b0;
    logic          p_busy   = 1'b0;
    logic          p_hs     = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            if (bus.rd_req && bus.rd_gnt) rd_q.push_back(bus.rd_addr);
            if (bus.win_valid && bus.win_ready) begin
                mon_t.d = bus.win_data;
                mon_t.f = bus.win_first;
                mon_t.l = bus.win_last;
                mon_t.c = center_addr;
                tap_q.push_back(mon_t);
                $display("tap #%0d data=%02h first=%0b last=%0b center=%0d",
                         tap_q.size() - 1, mon_t.d, mon_t.f, mon_t.l, mon_t.c);
            end
            if (frame_done) done_cnt++;
            if (p_rdv && p_busy && !bus.win_valid) lat_viol++;
            if (p_hs && !frame_done && !bus.rd_req) lat_viol++;
            p_rdv  = bus.rd_valid;
            p_busy = busy;
            p_hs   = bus.win_valid && bus.win_ready;
        end else begin
            p_rdv  = 1'b0;
            p_busy = 1'b0;
            p_hs   = 1'b0;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        rd_q.delete();
        tap_q.delete();
        lat_viol = 0;
    endtask

    task automatic pulse_start(input int m, input int n);
        @(posedge clk); #1;
        M     = 16'(m);
        N     = 16'(n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int c0;
        int cyc;
        c0  = done_cnt;
        cyc = 0;
        while (done_cnt == c0 && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
        end
        repeat (3) @(posedge clk);
        #1;
        check({tag, " done_pulses"}, done_cnt - c0, 1);
        check({tag, " busy_after"}, busy, 0);
    endtask

    task automatic check_frame(input string tag, input int m, input int n);
        int exp_a[$];
        int c, ci, cj, cols;
        logic [AW-1:0] a;
        for (int i = 2; i <= m - 3; i++)
            for (int j = 2; j <= n - 3; j++)
                for (int dy = -2; dy <= 2; dy++)
                    for (int dx = -2; dx <= 2; dx++)
                        exp_a.push_back((i + dy) * n + (j + dx));
        check({tag, " rd_count"}, rd_q.size(), exp_a.size());
        check({tag, " tap_count"}, tap_q.size(), exp_a.size());
        check({tag, " latency"}, lat_viol, 0);
        cols = n - 4;
        for (int k = 0; k < exp_a.size(); k++) begin
            a  = AW'(exp_a[k]);
            c  = k / 25;
            ci = 2 + c / cols;
            cj = 2 + c % cols;
            if (k < rd_q.size())
                check($sformatf("%s addr[%0d]", tag, k), rd_q[k], a);
            if (k < tap_q.size()) begin
                check($sformatf("%s data[%0d]", tag, k), tap_q[k].d, pix(a));
                check($sformatf("%s first[%0d]", tag, k), tap_q[k].f, (k % 25) == 0);
                check($sformatf("%s last[%0d]", tag, k), tap_q[k].l, (k % 25) == 24);
                check($sformatf("%s center[%0d]", tag, k), tap_q[k].c, AW'(ci * n + cj));
            end
        end
    endtask

    initial begin
        int tap;
        int cyc;
        int dc;

        bus.rd_gnt    = 1'b1;
        bus.win_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst rd_req", bus.rd_req, 0);
        check("rst win_valid", bus.win_valid, 0);
        check("rst busy", busy, 0);
        check("rst frame_done", frame_done, 0);
        check("rst frame_err", frame_err, 0);
        check("rst center", center_addr, 0);
        check("rst rd_addr", bus.rd_addr, 0);
        check("rst win_data", bus.win_data, 0);
        rst = 1'b1;

        // A: 5x5 single center
        clear_logs();
        pulse_start(5, 5);
        check("A busy", busy, 1);
        wait_done("A", 400);
        check_frame("A", 5, 5);
        check("A frame_err", frame_err, 0);

        // B: 6x5 two centers
        clear_logs();
        pulse_start(6, 5);
        wait_done("B", 800);
        check_frame("B", 6, 5);
        check("B c0", tap_q[0].c, 12);
        check("B c1", tap_q[25].c, 17);
        check("B first2", rd_q[25], 5);
        check("B last2", rd_q[49], 29);

        // C: detector stalls on tap 3
        clear_logs();
        bus.win_ready = 1'b0;
        pulse_start(5, 5);
        tap = 0;
        cyc = 0;
        while (tap < 25 && cyc < 2000) begin
            if (bus.win_valid) begin
                if (tap == 3) begin
                    bus.win_ready = 1'b0;
                    for (int h = 0; h < 4; h++) begin
                        @(posedge clk); #1;
                        check($sformatf("C hold valid %0d", h), bus.win_valid, 1);
                        check($sformatf("C hold data %0d", h), bus.win_data, pix(8'd3));
                        check($sformatf("C hold rd_req %0d", h), bus.rd_req, 0);
                    end
                end
                bus.win_ready = 1'b1;
                tap++;
            end else begin
                bus.win_ready = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.win_ready = 1'b1;
        wait_done("C", 200);
        check_frame("C", 5, 5);

        // D: too-small frame, then error cleared
        clear_logs();
        pulse_start(4, 9);
        check("D done", frame_done, 1);
        check("D busy", busy, 0);
        check("D err", frame_err, 1);
        @(posedge clk); #1;
        check("D done_off", frame_done, 0);
        check("D err_sticky", frame_err, 1);
        check("D no_reads", rd_q.size(), 0);
        pulse_start(5, 5);
        check("D err_clr", frame_err, 0);
        wait_done("D", 400);
        check_frame("D", 5, 5);

        // E: reset in the middle of the window
        clear_logs();
        pulse_start(5, 5);
        cyc = 0;
        while (tap_q.size() < 10 && cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
        end
        dc  = done_cnt;
        rst = 1'b0;
        #1;
        check("E rd_req", bus.rd_req, 0);
        check("E win_valid", bus.win_valid, 0);
        check("E win_first", bus.win_first, 0);
        check("E win_last", bus.win_last, 0);
        check("E busy", busy, 0);
        check("E center", center_addr, 0);
        check("E rd_addr", bus.rd_addr, 0);
        check("E win_data", bus.win_data, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        inj_valid = 1'b1;
        @(posedge clk); #1;
        inj_valid = 1'b0;
        check("E late_valid", bus.win_valid, 0);
        check("E late_busy", busy, 0);
        check("E no_done", done_cnt - dc, 0);
        clear_logs();
        pulse_start(5, 5);
        wait_done("E", 400);
        check_frame("E", 5, 5);

        // F: start and dimension changes while busy are ignored
        clear_logs();
        pulse_start(5, 5);
        repeat (6) @(posedge clk);
        #1;
        M     = 16'd9;
        N     = 16'd7;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("F", 400);
        check_frame("F", 5, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/window_fetch_ctrl.md
WINDOW_FETCH_CTRL -- requirements
Module: window_fetch_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, width of pixel-memory address.
REQ-002 Parameter WINDOW_N, default 2, window radius; window side K = 2*WINDOW_N+1.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  one-cycle frame-start request.
REQ-006 M, N  in  16 each  image rows, columns; sampled only on accepted start.
REQ-007 rd_req  out  1  pixel-memory read request.
REQ-008 rd_addr  out  ADDR_WIDTH  read address, valid while rd_req=1.
REQ-009 rd_gnt  in  1  memory accepts request this cycle.
REQ-010 rd_valid  in  1  read data returned.
REQ-011 rd_data  in  8  returned pixel.
REQ-012 win_valid  out  1  window tap available to detector.
REQ-013 win_data  out  8  tap pixel value.
REQ-014 win_first, win_last  out  1 each  first / last tap of current window.
REQ-015 win_ready  in  1  detector accepts tap.
REQ-016 center_addr  out  ADDR_WIDTH  i*N+j of current center.
REQ-017 busy  out  1  frame in progress.
REQ-018 frame_done  out  1  one-cycle pulse at frame end.
REQ-019 frame_err  out  1  sticky: last frame had no valid centers; cleared on next accepted start.

Function
REQ-020 Centers (i,j) SHALL be visited row-major, i in [WINDOW_N, M-WINDOW_N-1], j in [WINDOW_N, N-WINDOW_N-1].
REQ-021 Per center, taps SHALL be read in order dy=-WINDOW_N..WINDOW_N (outer), dx=-WINDOW_N..WINDOW_N (inner), rd_addr=(i+dy)*N+(j+dx).
REQ-022 Address arithmetic SHALL use 32-bit intermediates, result truncated to ADDR_WIDTH LSBs; no overflow flag.
REQ-023 FSM states: IDLE, REQ, WAIT, OUT, DONE.
REQ-024 IDLE: start=1 -> latch M,N, clear frame_err, set busy, go REQ; if M<K or N<K go DONE with frame_err=1, no reads issued.
REQ-025 REQ: rd_req=1, rd_addr stable until rd_gnt=1, then WAIT; exactly one read outstanding.
REQ-026 WAIT: on rd_valid, register rd_data into win_data, go OUT; rd_valid in any other state ignored.
REQ-027 OUT: win_valid=1, win_data/win_first/win_last/center_addr stable until win_ready=1; then advance tap and go REQ, or DONE after last tap of last center.
REQ-028 Latency: win_valid SHALL rise the cycle after rd_valid; rd_req SHALL rise the cycle after win_ready handshake.
REQ-029 win_first=1 only on tap (dy,dx)=(-W,-W); win_last=1 only on (W,W).
REQ-030 DONE: frame_done=1 for exactly one cycle, busy=0, return IDLE.
REQ-031 start while busy=1 SHALL be ignored; start in DONE cycle ignored.
REQ-032 M,N input changes during a frame SHALL have no effect.

Reset
REQ-033 rst=0 SHALL immediately force IDLE, counters to 0, rd_req=0, win_valid=0, win_first=0, win_last=0, busy=0, frame_done=0, frame_err=0, win_data=0, center_addr=0, rd_addr=0.
REQ-034 Reset mid-frame SHALL abandon the frame without frame_done; a late rd_valid after release SHALL be ignored.

Structure
REQ-035 Shared package noise_pkg SHALL hold the state enumeration and the K-from-WINDOW_N constant function.
REQ-036 Nested dy/dx tap counter SHALL be sub-module window_tap_counter (inc, wrap, first, last outputs); center i/j counters stay in the top.

Verification
REQ-037 M=5,N=5,W=2, ready always 1, 1-cycle memory -> single center, center_addr=12, rd_addr 0..24 in order, frame_done once.
REQ-038 M=6,N=5 -> two centers, center_addr 12 then 17; second window's first tap rd_addr=5, last=29; 50 taps total.
REQ-039 win_ready held 0 for 4 cycles on tap 3 -> win_valid and win_data held, no new rd_req until handshake.
REQ-040 M=4,N=9 -> no rd_req, frame_done pulse 1 cycle after start, frame_err=1; next start with M=5 clears it.
REQ-041 rst=0 asserted mid-window (tap 10) -> all outputs zero same cycle; new start restarts at rd_addr 0.
REQ-042 start pulsed during busy with different M -> ignored, frame completes with original dimensions.
